// File: rtl/fetch_controller.sv
// fetch_controller
// Single-outstanding instruction fetch sequencer. Issues one imem request at a
// time from pc_out, registers the returned word for decode and holds it until
// decode accepts it. Redirects (taken branch/jump) override everything and any
// response still in flight for the old stream is dropped.
//
// Build option: define FETCH_TIMEOUT_EN to add an imem wait counter and a
// sticky ERROR state entered after TIMEOUT_CYCLES cycles without imem_ack.
// Without it FETCH waits forever and fetch_err is tied low.
module fetch_controller #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        pc_en,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the cycle that would make
  // it TIMEOUT_CYCLES is the one that moves the FSM to ERROR instead.
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic        r_discard;    // next imem_ack belongs to a redirected-away request
  logic        r_halt_pend;  // halt seen, stop at the next handshake-free point

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instr_pc_nxt;
  logic        w_valid_nxt;
  logic        w_discard_nxt;
  logic        w_halt_pend_nxt;
  logic        w_halt_seen;
  logic        w_pc_en;

  assign w_halt_seen = r_halt_pend | halt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, delivered word and control flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0;
      r_instr_pc  <= 32'h0;
      r_valid     <= 1'b0;
      r_discard   <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_instr     <= w_instr_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_valid     <= w_valid_nxt;
      r_discard   <= w_discard_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Cycles spent in FETCH without a response or redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait_nxt;
    end
  end
`endif

  // Next-state, datapath updates and the sequential-advance strobe
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_instr_nxt     = r_instr;
    w_instr_pc_nxt  = r_instr_pc;
    w_valid_nxt     = r_valid;
    w_discard_nxt   = r_discard;
    w_halt_pend_nxt = w_halt_seen;
    w_pc_en         = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    w_wait_nxt      = '0;
`endif

    case (r_state)
      S_IDLE: begin
        // Nothing outstanding here, so a halt is consumed on the spot and
        // also overrides a simultaneous start.
        w_halt_pend_nxt = 1'b0;
        if (redirect) begin
          w_pc_nxt = redirect_target;
        end else if (start && !halt) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect) begin
          // A response arriving this same cycle is for the old stream and is
          // dropped now; otherwise the flag drops the one still in flight.
          w_pc_nxt      = redirect_target;
          w_discard_nxt = ~imem_ack;
        end else if (imem_ack) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
          end else begin
            w_instr_nxt    = imem_rdata;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = r_pc + 32'd4;
            w_pc_en        = 1'b1;
            w_state_nxt    = S_HOLD;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_wait == WAIT_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
`endif
      end

      S_HOLD: begin
        if (redirect) begin
          // The held word is on the wrong path: withdraw it even if decode
          // is accepting it this cycle.
          w_valid_nxt = 1'b0;
          w_pc_nxt    = redirect_target;
          w_state_nxt = S_FETCH;
        end else if (instr_ready) begin
          w_valid_nxt = 1'b0;
          if (w_halt_seen) begin
            w_halt_pend_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end

`ifdef FETCH_TIMEOUT_EN
      S_ERROR: begin
        // Sticky until reset; inputs are ignored.
        w_state_nxt = S_ERROR;
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_en       = w_pc_en;
  assign busy        = (r_state != S_IDLE);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = (r_state == S_ERROR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
module tb_fetch_controller;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TO     = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, halt, redirect, imem_ack, instr_ready;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, instr_valid, pc_en, busy, fetch_err;
  logic [31:0] imem_addr, instr, instr_pc, pc_out;

  int n_checks = 0;
  int n_errors = 0;

  fetch_controller #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .pc_en(pc_en),
    .pc_out(pc_out), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- table-driven directed vectors ----------------
  typedef struct {
    logic st, hl, rd; logic [31:0] tgt; logic ak; logic [31:0] rdat; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_instr, e_ipc, e_pc;
    logic e_pen, e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, hl, rd, input logic [31:0] tgt,
                              input logic ak, input logic [31:0] rdat, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                              input logic [31:0] e_instr, e_ipc, e_pc,
                              input logic e_pen, e_busy);
    vec_t v;
    v.st = st; v.hl = hl; v.rd = rd; v.tgt = tgt; v.ak = ak; v.rdat = rdat; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_pen = e_pen; v.e_busy = e_busy;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Abstract view: running or not, a word on offer to decode or not, number
  // of stale responses still to swallow, and a sticky error.
  bit          m_run, m_offer, m_err, m_halt, m_pc_en;
  int          m_stale, m_wait;
  logic [31:0] m_pc, m_word, m_wpc;

  task automatic model_reset();
    m_run = 0; m_offer = 0; m_err = 0; m_halt = 0; m_pc_en = 0;
    m_stale = 0; m_wait = 0;
    m_pc = RST_PC; m_word = 32'h0; m_wpc = 32'h0;
  endtask

  task automatic model_step();
    m_pc_en = 1'b0;
    if (m_err) return;
    if (!m_run) begin
      m_halt = 1'b0;
      if (redirect) m_pc = redirect_target;
      else if (start && !halt) m_run = 1'b1;
      return;
    end
    if (halt) m_halt = 1'b1;
    if (m_offer) begin
      if (redirect) begin
        m_offer = 1'b0;
        m_pc = redirect_target;
      end else if (instr_ready) begin
        m_offer = 1'b0;
        if (m_halt) begin
          m_run = 1'b0;
          m_halt = 1'b0;
        end
      end
    end else if (redirect) begin
      m_pc = redirect_target;
      m_stale = imem_ack ? 0 : 1;
      m_wait = 0;
    end else if (imem_ack) begin
      m_wait = 0;
      if (m_stale > 0) begin
        m_stale = m_stale - 1;
      end else begin
        m_word = imem_rdata;
        m_wpc = m_pc;
        m_pc = m_pc + 32'd4;
        m_offer = 1'b1;
        m_pc_en = 1'b1;
      end
    end else begin
      m_wait = m_wait + 1;
`ifdef FETCH_TIMEOUT_EN
      if (m_wait >= TO) m_err = 1'b1;
`endif
    end
  endtask

  task automatic compare_model();
    chk1 ("rnd.imem_req", imem_req, m_run && !m_offer && !m_err);
    chk32("rnd.imem_addr", imem_addr, m_pc);
    chk32("rnd.pc_out", pc_out, m_pc);
    chk1 ("rnd.instr_valid", instr_valid, m_offer);
    chk32("rnd.instr", instr, m_word);
    chk32("rnd.instr_pc", instr_pc, m_wpc);
    chk1 ("rnd.busy", busy, m_run);
    chk1 ("rnd.fetch_err", fetch_err, m_err);
  endtask

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_0004, A2 = 32'h3333_0008;
  localparam logic [31:0] A3 = 32'h4444_0040, A4 = 32'h5555_0100, A5 = 32'h6666_0300;

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    // reset state
    chk1 ("rst.imem_req", imem_req, 1'b0);
    chk32("rst.imem_addr", imem_addr, RST_PC);
    chk32("rst.pc_out", pc_out, RST_PC);
    chk1 ("rst.instr_valid", instr_valid, 1'b0);
    chk32("rst.instr", instr, 32'h0);
    chk32("rst.instr_pc", instr_pc, 32'h0);
    chk1 ("rst.pc_en", pc_en, 1'b0);
    chk1 ("rst.busy", busy, 1'b0);
    chk1 ("rst.fetch_err", fetch_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    //              st hl rd tgt       ak rdat         rdy  req addr      vld instr ipc       pc        pen busy
    tv.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'h0,    0, 32'h0, 32'h0,  32'h0,    0, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   1, 32'h0,    0, 32'h0, 32'h0,  32'h0,    0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A0,          1,   1, 32'h0,    0, 32'h0, 32'h0,  32'h0,    1, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'h4,    1, A0,    32'h0,  32'h4,    0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   1, 32'h4,    0, 32'h0, 32'h0,  32'h4,    0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A1,          1,   1, 32'h4,    0, 32'h0, 32'h0,  32'h4,    1, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'h8,    1, A1,    32'h4,  32'h8,    0, 1));
    tv.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,       1,   1, 32'h8,    0, 32'h0, 32'h0,  32'h8,    0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A2,          1,   1, 32'h8,    0, 32'h0, 32'h0,  32'h8,    1, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'hC,    1, A2,    32'h8,  32'hC,    0, 1));
    tv.push_back(mk(0, 0, 1, 32'h40,   0, 32'h0,       1,   0, 32'hC,    0, 32'h0, 32'h0,  32'hC,    0, 0));
    tv.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,       1,   0, 32'h40,   0, 32'h0, 32'h0,  32'h40,   0, 0));
    tv.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'h40,   0, 32'h0, 32'h0,  32'h40,   0, 0));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A3,          0,   1, 32'h40,   0, 32'h0, 32'h0,  32'h40,   1, 1));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,       0,   0, 32'h44,   1, A3,    32'h40, 32'h44,   0, 1));
    tv.push_back(mk(0, 0, 1, 32'h200,  0, 32'h0,       1,   0, 32'h44,   1, A3,    32'h40, 32'h44,   0, 1));
    tv.push_back(mk(0, 0, 1, 32'h100,  0, 32'h0,       1,   1, 32'h200,  0, 32'h0, 32'h0,  32'h200,  0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, 32'hDEAD,    1,   1, 32'h100,  0, 32'h0, 32'h0,  32'h100,  0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   1, 32'h100,  0, 32'h0, 32'h0,  32'h100,  0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A4,          1,   1, 32'h100,  0, 32'h0, 32'h0,  32'h100,  1, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   0, 32'h104,  1, A4,    32'h100, 32'h104, 0, 1));
    tv.push_back(mk(0, 0, 1, 32'h300,  1, 32'hBEEF,    1,   1, 32'h104,  0, 32'h0, 32'h0,  32'h104,  0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       1,   1, 32'h300,  0, 32'h0, 32'h0,  32'h300,  0, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    1, A5,          0,   1, 32'h300,  0, 32'h0, 32'h0,  32'h300,  1, 1));
    tv.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,       0,   0, 32'h304,  1, A5,    32'h300, 32'h304, 0, 1));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start = tv[i].st; halt = tv[i].hl; redirect = tv[i].rd; redirect_target = tv[i].tgt;
      imem_ack = tv[i].ak; imem_rdata = tv[i].rdat; instr_ready = tv[i].rdy;
      #1;
      chk1 ($sformatf("row%0d.imem_req", i), imem_req, tv[i].e_req);
      chk32($sformatf("row%0d.imem_addr", i), imem_addr, tv[i].e_addr);
      chk1 ($sformatf("row%0d.instr_valid", i), instr_valid, tv[i].e_vld);
      chk32($sformatf("row%0d.pc_out", i), pc_out, tv[i].e_pc);
      chk1 ($sformatf("row%0d.pc_en", i), pc_en, tv[i].e_pen);
      chk1 ($sformatf("row%0d.busy", i), busy, tv[i].e_busy);
      if (tv[i].e_vld) begin
        chk32($sformatf("row%0d.instr", i), instr, tv[i].e_instr);
        chk32($sformatf("row%0d.instr_pc", i), instr_pc, tv[i].e_ipc);
      end
    end

    // ---- reset in the middle of a FETCH, then a late ack while IDLE ----
    apply_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 chk1("midf.pre_req", imem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1 ("midf.imem_req", imem_req, 1'b0);
    chk1 ("midf.busy", busy, 1'b0);
    chk32("midf.imem_addr", imem_addr, RST_PC);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("lateack%0d.valid", k), instr_valid, 1'b0);
      chk1($sformatf("lateack%0d.busy", k), busy, 1'b0);
      chk1($sformatf("lateack%0d.pc_en", k), pc_en, 1'b0);
      @(negedge clk);
    end
    imem_ack = 1'b0;

    // ---- asynchronous reset while a word is held for decode ----
    instr_ready = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hC0DE_0001;
    @(negedge clk); imem_ack = 1'b0;
    #1;
    chk1 ("midh.pre_valid", instr_valid, 1'b1);
    chk32("midh.pre_instr", instr, 32'hC0DE_0001);
    #2 reset = 1'b0;
    #1;
    chk1 ("midh.valid", instr_valid, 1'b0);
    chk32("midh.instr", instr, 32'h0);
    chk32("midh.instr_pc", instr_pc, 32'h0);
    chk32("midh.pc_out", pc_out, RST_PC);
    chk1 ("midh.busy", busy, 1'b0);
    @(negedge clk); reset = 1'b1;

`ifdef FETCH_TIMEOUT_EN
    // ---- imem never answers ----
    apply_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (TO - 1) @(negedge clk);
    #1;
    chk1("to.before_err", fetch_err, 1'b0);
    chk1("to.before_req", imem_req, 1'b1);
    @(negedge clk);
    #1;
    chk1("to.err", fetch_err, 1'b1);
    chk1("to.req", imem_req, 1'b0);
    imem_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h500; start = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk1("to.sticky_err", fetch_err, 1'b1);
    chk1("to.sticky_req", imem_req, 1'b0);
    chk1("to.sticky_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk1("to.cleared_err", fetch_err, 1'b0);
    chk1("to.cleared_busy", busy, 1'b0);
    @(negedge clk); idle_inputs(); reset = 1'b1;
`endif

    // ---- randomized run against the reference model ----
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      compare_model();
      if (cyc % 250 == 249) begin
        reset = 1'b0;
        #1;
        model_reset();
        compare_model();
        continue;
      end
      start           = ($urandom_range(0, 1) == 1);
      halt            = ($urandom_range(0, 19) == 0);
      redirect        = ($urandom_range(0, 11) == 0);
      redirect_target = $urandom;
      imem_ack        = ($urandom_range(0, 9) < 4);
      imem_rdata      = $urandom;
      instr_ready     = ($urandom_range(0, 2) != 0);
      #1;
      model_step();
      chk1("rnd.pc_en", pc_en, m_pc_en);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
